// File: rtl/wb_master_if.sv
// Command/response handshake and Wishbone bus bundle for wb_master.
// The master modport is the wb_master side; slave is the requester/bus environment.
interface wb_master_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_we;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        wb_cyc;
  logic        wb_stb;
  logic        wb_we;
  logic [31:0] wb_addr;
  logic [31:0] wb_data_o;
  logic [31:0] wb_data_i;
  logic        wb_ack;

  modport master (
    input  cmd_valid, cmd_we, cmd_addr, cmd_wdata, rsp_ready, wb_data_i, wb_ack,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
           wb_cyc, wb_stb, wb_we, wb_addr, wb_data_o
  );

  modport slave (
    output cmd_valid, cmd_we, cmd_addr, cmd_wdata, rsp_ready, wb_data_i, wb_ack,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
           wb_cyc, wb_stb, wb_we, wb_addr, wb_data_o
  );
endinterface

// File: rtl/wb_master.sv
// Single-outstanding Wishbone master bridging a valid/ready command/response port.
// Optional bus timeout abort enabled by defining WB_MASTER_TIMEOUT_EN.
module wb_master #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input logic        clk,
  input logic        rst_n,
  wb_master_if.master bus
);

  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

  state_t      state_q, state_d;
  logic        cyc_q, cyc_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rdata_q, rdata_d;

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("wb_master: TIMEOUT_CYCLES must be within 2..255");
  end

`ifdef WB_MASTER_TIMEOUT_EN
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] cnt_q, cnt_d;
  logic       err_q, err_d;
`endif

  always_comb begin
    state_d     = state_q;
    cyc_d       = cyc_q;
    we_d        = we_q;
    addr_d      = addr_q;
    data_d      = data_q;
    rsp_valid_d = rsp_valid_q;
    rdata_d     = rdata_q;
`ifdef WB_MASTER_TIMEOUT_EN
    cnt_d       = cnt_q;
    err_d       = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.cmd_valid) begin
          state_d = BUS;
          cyc_d   = 1'b1;
          we_d    = bus.cmd_we;
          addr_d  = bus.cmd_addr;
          data_d  = bus.cmd_wdata;
`ifdef WB_MASTER_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      BUS: begin
        // An ack on the timeout edge takes priority over the abort.
        if (bus.wb_ack) begin
          state_d     = RESP;
          cyc_d       = 1'b0;
          rsp_valid_d = 1'b1;
          rdata_d     = we_q ? '0 : bus.wb_data_i;
`ifdef WB_MASTER_TIMEOUT_EN
          err_d       = 1'b0;
        end else if (cnt_q == CNT_LAST) begin
          state_d     = RESP;
          cyc_d       = 1'b0;
          rsp_valid_d = 1'b1;
          rdata_d     = '0;
          err_d       = 1'b1;
        end else begin
          cnt_d       = cnt_q + 8'd1;
`endif
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cyc_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      rsp_valid_q <= 1'b0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      cyc_q       <= cyc_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      rsp_valid_q <= rsp_valid_d;
      rdata_q     <= rdata_d;
    end
  end

`ifdef WB_MASTER_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign bus.rsp_err = err_q;
`else
  assign bus.rsp_err = 1'b0;
`endif

  assign bus.cmd_ready = (state_q == IDLE);
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rdata_q;
  assign bus.wb_cyc    = cyc_q;
  assign bus.wb_stb    = cyc_q;
  assign bus.wb_we     = we_q;
  assign bus.wb_addr   = addr_q;
  assign bus.wb_data_o = data_q;

endmodule

// File: tb/tb_wb_master.sv
// Self-checking bench for wb_master: directed corner cases plus randomized
// transactions against a per-transaction outcome model of the bridge.
module tb_wb_master;
  localparam int unsigned T = 16;

  logic clk = 1'b0;
  logic rst_n;
  int unsigned passed = 0;
  int unsigned total  = 0;

  wb_master_if bus_if ();

  wb_master #(.TIMEOUT_CYCLES(T)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit exceeded");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
  endtask

  // d: cycles after acceptance before the slave raises ack (ack is seen d+1 edges after E0)
  task automatic run_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] rdata, input int unsigned d,
                         input int unsigned hold, input bit hold_valid, input bit spurious);
    int unsigned cyc_cnt;
    int unsigned exp_cyc;
    logic [31:0] exp_rdata;
    logic        exp_err;
    bit          timed;
`ifdef WB_MASTER_TIMEOUT_EN
    timed = (d >= T);
`else
    timed = 1'b0;
`endif
    exp_cyc   = timed ? T : d + 1;
    exp_err   = timed;
    exp_rdata = (we || timed) ? 32'h0 : rdata;

    bus_if.cmd_valid = 1'b1;
    bus_if.cmd_we    = we;
    bus_if.cmd_addr  = addr;
    bus_if.cmd_wdata = wdata;
    bus_if.rsp_ready = 1'b0;
    check("cmd_ready_idle", {31'b0, bus_if.cmd_ready}, 32'd1);
    tick;
    if (!hold_valid) bus_if.cmd_valid = 1'b0;
    bus_if.cmd_we    = ~we;
    bus_if.cmd_addr  = $urandom;
    bus_if.cmd_wdata = $urandom;
    check("cyc_after_accept", {31'b0, bus_if.wb_cyc}, 32'd1);
    check("stb_after_accept", {31'b0, bus_if.wb_stb}, 32'd1);
    check("wb_we_latched", {31'b0, bus_if.wb_we}, {31'b0, we});
    check("wb_addr_latched", bus_if.wb_addr, addr);
    check("wb_data_o_latched", bus_if.wb_data_o, wdata);
    check("cmd_ready_bus", {31'b0, bus_if.cmd_ready}, 32'd0);

    cyc_cnt = 0;
    for (int unsigned n = 0; n < 400 && bus_if.wb_cyc; n++) begin
      bus_if.wb_ack    = (n >= d);
      bus_if.wb_data_i = (n >= d) ? rdata : $urandom;
      tick;
      cyc_cnt++;
      bus_if.wb_ack    = 1'b0;
      bus_if.wb_data_i = $urandom;
      if (bus_if.wb_cyc) begin
        check("bus_addr_stable", bus_if.wb_addr, addr);
        check("bus_data_stable", bus_if.wb_data_o, wdata);
        check("bus_we_stable", {31'b0, bus_if.wb_we}, {31'b0, we});
        check("bus_no_rsp", {31'b0, bus_if.rsp_valid}, 32'd0);
      end
    end
    check("cyc_high_cycles", cyc_cnt, exp_cyc);
    check("cyc_low_at_rsp", {31'b0, bus_if.wb_cyc}, 32'd0);
    check("stb_low_at_rsp", {31'b0, bus_if.wb_stb}, 32'd0);
    check("rsp_valid_latency", {31'b0, bus_if.rsp_valid}, 32'd1);
    check("rsp_rdata", bus_if.rsp_rdata, exp_rdata);
    check("rsp_err", {31'b0, bus_if.rsp_err}, {31'b0, exp_err});
    check("cmd_ready_resp", {31'b0, bus_if.cmd_ready}, 32'd0);

    for (int unsigned k = 0; k < hold; k++) begin
      bus_if.wb_ack = spurious ? 1'($urandom_range(0, 1)) : 1'b0;
      tick;
      check("hold_rsp_valid", {31'b0, bus_if.rsp_valid}, 32'd1);
      check("hold_rsp_rdata", bus_if.rsp_rdata, exp_rdata);
      check("hold_rsp_err", {31'b0, bus_if.rsp_err}, {31'b0, exp_err});
      check("hold_cmd_ready", {31'b0, bus_if.cmd_ready}, 32'd0);
      check("hold_no_cyc", {31'b0, bus_if.wb_cyc}, 32'd0);
    end
    bus_if.wb_ack    = 1'b0;
    bus_if.rsp_ready = 1'b1;
    tick;
    bus_if.rsp_ready = 1'b0;
    check("rsp_valid_cleared", {31'b0, bus_if.rsp_valid}, 32'd0);
    check("cmd_ready_back", {31'b0, bus_if.cmd_ready}, 32'd1);
    check("no_cyc_at_handshake", {31'b0, bus_if.wb_cyc}, 32'd0);
    check("wb_addr_held", bus_if.wb_addr, addr);
    check("wb_we_held", {31'b0, bus_if.wb_we}, {31'b0, we});
    check("wb_data_o_held", bus_if.wb_data_o, wdata);
    bus_if.cmd_valid = 1'b0;
  endtask

  initial begin
    rst_n            = 1'b0;
    bus_if.cmd_valid = 1'b0;
    bus_if.cmd_we    = 1'b0;
    bus_if.cmd_addr  = '0;
    bus_if.cmd_wdata = '0;
    bus_if.rsp_ready = 1'b0;
    bus_if.wb_data_i = '0;
    bus_if.wb_ack    = 1'b0;
    tick;
    tick;
    check("rst_cmd_ready", {31'b0, bus_if.cmd_ready}, 32'd1);
    check("rst_cyc", {31'b0, bus_if.wb_cyc}, 32'd0);
    check("rst_stb", {31'b0, bus_if.wb_stb}, 32'd0);
    check("rst_we", {31'b0, bus_if.wb_we}, 32'd0);
    check("rst_addr", bus_if.wb_addr, 32'd0);
    check("rst_data_o", bus_if.wb_data_o, 32'd0);
    check("rst_rsp_valid", {31'b0, bus_if.rsp_valid}, 32'd0);
    check("rst_rsp_rdata", bus_if.rsp_rdata, 32'd0);
    check("rst_rsp_err", {31'b0, bus_if.rsp_err}, 32'd0);
    rst_n = 1'b1;
    tick;
    check("cmd_ready_after_release", {31'b0, bus_if.cmd_ready}, 32'd1);

    // Registered-ack write, then read.
    run_txn(1'b1, 32'h0000_0000, 32'h0000_00A5, 32'h1234_5678, 1, 0, 1'b0, 1'b0);
    run_txn(1'b0, 32'h0000_0004, $urandom, 32'h0000_00FF, 1, 1, 1'b0, 1'b0);
    // Back-pressured response with cmd_valid held and stray acks in RESP.
    run_txn(1'b0, 32'h0000_0100, 32'h0, 32'hCAFE_F00D, 2, 5, 1'b1, 1'b1);

    // Stray ack in IDLE produces nothing.
    bus_if.wb_ack = 1'b1;
    tick;
    bus_if.wb_ack = 1'b0;
    check("idle_ack_no_rsp", {31'b0, bus_if.rsp_valid}, 32'd0);
    check("idle_ack_no_cyc", {31'b0, bus_if.wb_cyc}, 32'd0);
    check("idle_ack_ready", {31'b0, bus_if.cmd_ready}, 32'd1);

`ifdef WB_MASTER_TIMEOUT_EN
    run_txn(1'b0, 32'h0000_0008, 32'h0, 32'hDEAD_BEEF, 100, 2, 1'b0, 1'b0);
    run_txn(1'b0, 32'h0000_000C, 32'h0, 32'hBEEF_0001, T - 1, 1, 1'b0, 1'b0);
    run_txn(1'b1, 32'h0000_0010, 32'h5A5A_5A5A, 32'h0, T - 2, 0, 1'b0, 1'b0);
`else
    run_txn(1'b0, 32'h0000_0008, 32'h0, 32'hDEAD_BEEF, 40, 2, 1'b0, 1'b0);
`endif

    // Reset one cycle into BUS aborts the cycle with no response.
    bus_if.cmd_valid = 1'b1;
    bus_if.cmd_we    = 1'b1;
    bus_if.cmd_addr  = 32'h0000_0020;
    bus_if.cmd_wdata = 32'h0000_0077;
    tick;
    bus_if.cmd_valid = 1'b0;
    tick;
    check("pre_reset_cyc", {31'b0, bus_if.wb_cyc}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("async_rst_cyc", {31'b0, bus_if.wb_cyc}, 32'd0);
    check("async_rst_stb", {31'b0, bus_if.wb_stb}, 32'd0);
    check("async_rst_rsp", {31'b0, bus_if.rsp_valid}, 32'd0);
    check("async_rst_ready", {31'b0, bus_if.cmd_ready}, 32'd1);
    check("async_rst_addr", bus_if.wb_addr, 32'd0);
    check("async_rst_data_o", bus_if.wb_data_o, 32'd0);
    #2;
    rst_n = 1'b1;
    tick;
    check("post_rst_ready", {31'b0, bus_if.cmd_ready}, 32'd1);
    check("post_rst_no_rsp", {31'b0, bus_if.rsp_valid}, 32'd0);
    check("post_rst_no_cyc", {31'b0, bus_if.wb_cyc}, 32'd0);

    for (int i = 0; i < 25; i++) begin
      run_txn(1'($urandom_range(0, 1)), $urandom, $urandom, $urandom,
              $urandom_range(0, 20), $urandom_range(0, 3),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/wb_master.md
WB_MASTER -- requirements
Module: wb_master

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 16, bus cycles allowed before abort; legal range 2..255.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 cmd_valid  input  1  requester presents a command.
REQ-005 cmd_ready  output  1  block accepts a command this cycle.
REQ-006 cmd_we  input  1  1 = write, 0 = read.
REQ-007 cmd_addr  input  32  byte address of the command.
REQ-008 cmd_wdata  input  32  write data of the command.
REQ-009 rsp_valid  output  1  response available.
REQ-010 rsp_ready  input  1  requester consumes the response.
REQ-011 rsp_rdata  output  32  read data; 0 for writes and errors.
REQ-012 rsp_err  output  1  1 = transaction aborted by timeout.
REQ-013 wb_cyc, wb_stb  output  1 each  Wishbone cycle and strobe.
REQ-014 wb_we  output  1  Wishbone write enable.
REQ-015 wb_addr  output  32  Wishbone address.
REQ-016 wb_data_o  output  32  Wishbone write data.
REQ-017 wb_data_i  input  32  Wishbone read data.
REQ-018 wb_ack  input  1  Wishbone acknowledge.

Function
REQ-019 The FSM SHALL have states IDLE, BUS, RESP; cmd_ready = (state == IDLE); all Wishbone outputs registered.
REQ-020 IDLE: on cmd_valid && cmd_ready at edge E0, SHALL latch cmd_we/addr/wdata onto wb_we/wb_addr/wb_data_o, assert wb_cyc = wb_stb = 1 after E0, enter BUS.
REQ-021 BUS: wb_cyc, wb_stb, wb_we, wb_addr, wb_data_o SHALL remain stable until the cycle ends.
REQ-022 BUS, wb_ack = 1 sampled at an edge: SHALL deassert wb_cyc/wb_stb at that same edge, capture rsp_rdata = wb_data_i (read) or 0 (write), rsp_err = 0, assert rsp_valid, enter RESP.
REQ-023 Latency: rsp_valid SHALL rise on the edge that samples wb_ack; with a registered-ack slave that is E0+2.
REQ-024 RESP: rsp_valid, rsp_rdata, rsp_err SHALL hold until rsp_valid && rsp_ready at an edge; then rsp_valid = 0, return to IDLE; cmd_ready stays 0 throughout RESP.
REQ-025 wb_ack sampled in IDLE or RESP SHALL be ignored (no state change, no second response).
REQ-026 At most one Wishbone cycle outstanding; no pipelining, no back-to-back cycles without passing through RESP and IDLE.
REQ-027 wb_data_o SHALL keep its value when not in BUS; wb_we/wb_addr hold last value.

Reset
REQ-028 rst_n = 0 SHALL immediately force state = IDLE, wb_cyc = wb_stb = wb_we = 0, wb_addr = wb_data_o = 0, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, timeout counter = 0.
REQ-029 Reset during BUS SHALL drop wb_cyc/wb_stb asynchronously; the aborted command produces no response.
REQ-030 After rst_n rises, cmd_ready SHALL be 1 on the first clock edge.

Configuration
REQ-031 Macro WB_MASTER_TIMEOUT_EN defined: an 8-bit counter SHALL clear on entering BUS, increment each BUS cycle without ack, and when it equals TIMEOUT_CYCLES-1 with wb_ack = 0 the block SHALL deassert wb_cyc/wb_stb, set rsp_err = 1, rsp_rdata = 0, enter RESP (wb_cyc high exactly TIMEOUT_CYCLES cycles).
REQ-032 wb_ack = 1 on the timeout edge SHALL win: normal completion, rsp_err = 0.
REQ-033 Macro undefined: no counter is synthesised, BUS waits indefinitely for wb_ack, rsp_err SHALL be constant 0, TIMEOUT_CYCLES is unused.

Verification
REQ-034 Write cmd addr 0x0000_0000 data 0x0000_00A5 to a registered-ack slave -> wb_we = 1, wb_cyc high 2 cycles, wb_data_o = 0x0000_00A5, rsp_valid at E0+2, rsp_err = 0, rsp_rdata = 0.
REQ-035 Read cmd addr 0x0000_0004, slave returns 0x0000_00FF -> rsp_rdata = 0x0000_00FF, rsp_err = 0, wb_we = 0.
REQ-036 WB_MASTER_TIMEOUT_EN, TIMEOUT_CYCLES = 16, slave never acks -> wb_cyc high exactly 16 cycles, then rsp_valid = 1, rsp_err = 1, rsp_rdata = 0.
REQ-037 rsp_ready held 0 for 5 cycles after completion, cmd_valid held 1 -> rsp_* stable, cmd_ready = 0, no new wb_cyc until the cycle after rsp_ready = 1 handshake.
REQ-038 rst_n pulled low 1 cycle into BUS -> wb_cyc/wb_stb low before next edge, no rsp_valid, cmd_ready = 1 after release.
REQ-039 wb_ack asserted on the 16th BUS cycle (timeout edge) -> rsp_err = 0, rsp_rdata = wb_data_i.
